interrupt_controller: RTL

Interrupt source for the game processor. Merges a free-running system-timer tick and keyboard key strobes into the two-bit `IRQ` code the processor polls. It runs the `IACK`/`IEND` handshake and holds the acknowledged keystroke stable on `KEY_OUT` for the processor's key-buffer load. It sits between the keyboard controller/timebase and the processor's `INT_IRQ`, `INT_IACK`, `INT_IEND` and `KBD_KEY` pins.

---
 rtl/int_pkg.sv | 14 +
 rtl/irq_sat_counter.sv | 17 +
 rtl/interrupt_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared IRQ codes and controller state encoding.
package int_pkg;

  localparam logic [1:0] IRQ_TIMER = 2'b00;
  localparam logic [1:0] IRQ_KBD   = 2'b01;
  localparam logic [1:0] IRQ_NONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sat_counter.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module irq_sat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  // Count enabled events, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      count <= 8'd0;
    else if (inc && count != 8'hFF)
      count <= count + 8'd1;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Merges timer ticks and key strobes into the processor's IRQ code and runs
// the IACK/IEND handshake. Keyboard wins over timer when both are pending.
module interrupt_controller
  import int_pkg::*;
#(
  parameter int TICK_DIV = 1666667,
  parameter int TICK_W   = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_STROBE,
  input  logic [7:0] KEY_CODE,
  input  logic       IACK,
  input  logic       IEND,
  output logic [1:0] IRQ,
  output logic [7:0] KEY_OUT,
  output logic [7:0] KEY_DROPS,
  output logic [7:0] TICK_MISSES,
  output logic       PROTO_ERR
);

  state_t            state, state_nxt;
  logic [1:0]        irq_nxt;
  logic [TICK_W-1:0] tmr_cnt;
  logic              tick;
  logic              kbd_pend, tmr_pend;
  logic [7:0]        key_latch;
  logic              ack_ok, end_ok, kbd_ack, tmr_ack;
  logic              proto_bad, key_drop, tick_miss;

  assign tick = (tmr_cnt == TICK_W'(TICK_DIV - 1));

  // A pulse is only honoured in its own state and never alongside the other.
  assign ack_ok  = IACK && !IEND && (state == ST_ASSERT);
  assign end_ok  = IEND && !IACK && (state == ST_SERVICE);
  // IRQ holds the selected source for the whole ASSERT phase.
  assign kbd_ack = ack_ok && (IRQ == IRQ_KBD);
  assign tmr_ack = ack_ok && (IRQ == IRQ_TIMER);

  assign proto_bad = (IACK && state != ST_ASSERT) ||
                     (IEND && state != ST_SERVICE) ||
                     (IACK && IEND);

  // A same-edge acknowledge frees the slot, so the new event is not lost.
  assign key_drop  = KEY_STROBE && kbd_pend && !kbd_ack;
  assign tick_miss = tick && tmr_pend && !tmr_ack;

  // Free-running tick divider, unaffected by the handshake.
  always_ff @(posedge CLK) begin
    if (RESET || tick) tmr_cnt <= '0;
    else               tmr_cnt <= tmr_cnt + TICK_W'(1);
  end

  // Timer pending flag: a new tick outranks a same-edge acknowledge.
  always_ff @(posedge CLK) begin
    if (RESET)        tmr_pend <= 1'b0;
    else if (tick)    tmr_pend <= 1'b1;
    else if (tmr_ack) tmr_pend <= 1'b0;
  end

  // Key latch and pending flag; a busy latch keeps the oldest key.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      kbd_pend  <= 1'b0;
      key_latch <= 8'h00;
    end else if (KEY_STROBE && (!kbd_pend || kbd_ack)) begin
      kbd_pend  <= 1'b1;
      key_latch <= KEY_CODE;
    end else if (kbd_ack) begin
      kbd_pend  <= 1'b0;
    end
  end

  // Hand the pre-edge latch value to the processor on a keyboard acknowledge.
  always_ff @(posedge CLK) begin
    if (RESET)        KEY_OUT <= 8'h00;
    else if (kbd_ack) KEY_OUT <= key_latch;
  end

  // Sticky handshake-violation flag.
  always_ff @(posedge CLK) begin
    if (RESET)          PROTO_ERR <= 1'b0;
    else if (proto_bad) PROTO_ERR <= 1'b1;
  end

  // FSM state and registered IRQ code.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      IRQ   <= IRQ_NONE;
    end else begin
      state <= state_nxt;
      IRQ   <= irq_nxt;
    end
  end

  // Next state and IRQ selection; the source is chosen only from IDLE.
  always_comb begin
    state_nxt = state;
    irq_nxt   = IRQ;
    case (state)
      ST_IDLE: begin
        irq_nxt = IRQ_NONE;
        if (kbd_pend) begin
          state_nxt = ST_ASSERT;
          irq_nxt   = IRQ_KBD;
        end else if (tmr_pend) begin
          state_nxt = ST_ASSERT;
          irq_nxt   = IRQ_TIMER;
        end
      end
      ST_ASSERT: begin
        if (ack_ok) begin
          state_nxt = ST_SERVICE;
          irq_nxt   = IRQ_NONE;
        end
      end
      ST_SERVICE: begin
        irq_nxt = IRQ_NONE;
        if (end_ok) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        irq_nxt   = IRQ_NONE;
      end
    endcase
  end

  irq_sat_counter u_key_drops (
    .clk   (CLK),
    .reset (RESET),
    .inc   (key_drop),
    .count (KEY_DROPS)
  );

  irq_sat_counter u_tick_misses (
    .clk   (CLK),
    .reset (RESET),
    .inc   (tick_miss),
    .count (TICK_MISSES)
  );

endmodule
